pri_arb_enc: RTL and testbench
==============================

Name: pri_arb_enc

Overview:
- Parametrised, registered successor to the 4-input combinational priority encoder.
- Encodes an N-bit request vector into a binary index plus a one-hot grant.
- Holds each result under a valid/ready handshake until the consumer accepts it.
- Mode selects fixed priority (highest index wins) or round-robin, so shared-resource arbiters and interrupt encoders use one block.

Parameters:
- N, 8, number of request inputs (N ≥ 2).
- W, $clog2(N), index width (derived; do not override).
- RR_MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin, rotating from the last granted index.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector; bit i = requester i
- out_ready  input  1  consumer accepts the current result
- out_valid  output  1  out_idx/out_gnt hold a valid grant
- out_idx  output  W  binary index of the granted requester
- out_gnt  output  N  one-hot grant, bit out_idx set; all zero when out_valid=0
- out_none  output  1  registered flag: req was all-zero in the previous cycle (replaces the old all-ones "nothing detected" code)

Behaviour:
- Reset: synchronous on rst=1 at a clk edge.
  - out_valid=0, out_idx=0, out_gnt=0, out_none=1.
  - RR pointer ptr=0; state=IDLE.
  - rst overrides everything, including a grant in progress, which is dropped without handshake.
- Winner search (combinational, from req):
  - Fixed mode: the highest set bit, N-1 down to 0.
  - RR mode: search order ptr-1, ptr-2, …, 0, N-1, …, ptr (descending, wrapping). With ptr=0 the order is N-1..0, identical to fixed mode.
- State IDLE (out_valid=0):
  - If req≠0: register the winner into out_idx/out_gnt, set out_valid=1 next cycle, go to GRANT.
  - Latency from req to out_valid is exactly 1 cycle.
- State GRANT (out_valid=1):
  - While out_ready=0: out_idx, out_gnt and out_valid are held stable, even if req changes or the granted bit drops. The grant is latched.
  - On handshake (out_valid & out_ready at a clk edge):
    - RR mode: ptr <= out_idx. Fixed mode: ptr unused.
    - If req≠0 that cycle, re-arbitrate in the same edge using the updated search order (RR order starts from the just-granted index-1). Stay in GRANT with the new result. Back-to-back grants give one result per cycle.
    - If req=0, go to IDLE: out_valid=0, out_gnt=0, out_idx holds its last value.
- out_none is updated every cycle as (req==0), independent of state.
- out_ready while out_valid=0 is ignored.
- Single request in RR mode: it is granted repeatedly. ptr wraps naturally; index N-1 followed by a search wraps to N-2..0 then N-1.
- No combinational path from req or out_ready to any output.

Test Plan:
- Reset, N=8: assert rst 2 cycles with req=8'hFF -> out_valid=0, out_gnt=0, out_idx=0, out_none=1. Release rst -> out_valid=1 one cycle later with out_idx=7.
- Fixed priority, N=8, RR_MODE=0: req=8'b0010_0110, out_ready=1 held -> out_idx=5 every cycle (back-to-back); then req=8'b0000_0110 -> out_idx=2; then req=0 -> out_valid=0 next cycle, out_none=1.
- Backpressure: req=8'b1000_0001, out_ready=0 for 4 cycles, then req changed to 8'b0000_0001 -> out_idx stays 7, out_gnt=8'h80 for all 4 cycles. Assert out_ready -> next result idx=0.
- Round-robin, N=4, RR_MODE=1: req=4'b1111, out_ready=1 -> grant sequence 3,2,1,0,3,2 on consecutive cycles.
- RR skip/wrap, N=4: req=4'b1010, out_ready=1 -> sequence 3,1,3,1. Then ptr=1 with req=4'b0001 -> 0. Then req=4'b0001 again -> 0 (single-requester repeat).
- Reset mid-grant: out_valid=1, idx=5, out_ready=0; pulse rst 1 cycle -> out_valid=0, ptr=0. With req=8'b0010_0001 after release -> out_idx=5 (search restarts at N-1).

Source files
------------

// File: rtl/pri_arb_enc.sv
// Registered priority encoder / arbiter: fixed-priority or round-robin winner
// selection, holding each grant under a valid/ready handshake.
module pri_arb_enc #(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter int RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_gnt,
  output logic         out_none
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q;
  logic [W-1:0] ptr_q;
  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] gnt_q;
  logic         none_q;

  logic         hs;
  logic         any_req;
  logic [W-1:0] srch_ptr;
  logic [W-1:0] win_idx;
  logic [W:0]   pos;

  assign hs      = (state_q == GRANT) && out_ready;
  assign any_req = |req;

  // On a handshake edge the pointer update is folded in so the re-arbitration
  // already rotates past the index being retired this cycle.
  always_comb begin
    srch_ptr = '0;
    if (RR_MODE != 0) begin
      srch_ptr = hs ? idx_q : ptr_q;
    end
  end

  // Scan offsets ascending from the pointer; the last hit wins, which gives
  // priority to ptr-1, ptr-2, ... wrapping down to ptr itself.
  always_comb begin
    win_idx = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, srch_ptr} + (W+1)'(k);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end
      if (req[pos[W-1:0]]) begin
        win_idx = pos[W-1:0];
      end
    end
  end

  // Registered result stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      gnt_q   <= '0;
      none_q  <= 1'b1;
    end else begin
      none_q <= ~any_req;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            valid_q <= 1'b1;
            idx_q   <= win_idx;
            gnt_q   <= N'(1) << win_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (out_ready) begin
            if (RR_MODE != 0) begin
              ptr_q <= idx_q;
            end
            if (any_req) begin
              idx_q <= win_idx;
              gnt_q <= N'(1) << win_idx;
            end else begin
              valid_q <= 1'b0;
              gnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_gnt   = gnt_q;
  assign out_none  = none_q;

endmodule

// File: tb/tb_pri_arb_enc.sv
// Directed bench for pri_arb_enc: N=8 fixed priority, N=4 round-robin and
// N=8 round-robin instances driven from vector tables and short sequences.
module tb_pri_arb_enc;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] req8,  gnt8;
  logic       rdy8,  vld8,  none8;
  logic [2:0] idx8;

  logic [3:0] req4,  gnt4;
  logic       rdy4,  vld4,  none4;
  logic [1:0] idx4;

  logic [7:0] req8r, gnt8r;
  logic       rdy8r, vld8r, none8r;
  logic [2:0] idx8r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pri_arb_enc #(.N(8), .RR_MODE(0)) u8 (
    .clk(clk), .rst(rst), .req(req8), .out_ready(rdy8),
    .out_valid(vld8), .out_idx(idx8), .out_gnt(gnt8), .out_none(none8));

  pri_arb_enc #(.N(4), .RR_MODE(1)) u4 (
    .clk(clk), .rst(rst), .req(req4), .out_ready(rdy4),
    .out_valid(vld4), .out_idx(idx4), .out_gnt(gnt4), .out_none(none4));

  pri_arb_enc #(.N(8), .RR_MODE(1)) u8r (
    .clk(clk), .rst(rst), .req(req8r), .out_ready(rdy8r),
    .out_valid(vld8r), .out_idx(idx8r), .out_gnt(gnt8r), .out_none(none8r));

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic [7:0] gnt;
    logic       none;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic v, input logic [2:0] idx,
                      input logic [7:0] gnt, input logic none);
    chk({name, ".valid"}, 32'(vld8),  32'(v));
    chk({name, ".idx"},   32'(idx8),  32'(idx));
    chk({name, ".gnt"},   32'(gnt8),  32'(gnt));
    chk({name, ".none"},  32'(none8), 32'(none));
  endtask

  int rr_exp1[6];
  int rr_exp2[6];

  initial begin
    rst = 1'b1; req8 = 8'hFF; rdy8 = 1'b0;
    req4 = '0; rdy4 = 1'b0; req8r = '0; rdy8r = 1'b0;

    tbl[0]  = '{8'h26, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[1]  = '{8'h26, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[2]  = '{8'h26, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[3]  = '{8'h06, 1'b1, 1'b1, 3'd2, 8'h04, 1'b0};
    tbl[4]  = '{8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1};
    tbl[6]  = '{8'h81, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0};
    tbl[7]  = '{8'h81, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0};
    tbl[8]  = '{8'h01, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0};
    tbl[9]  = '{8'h01, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0};
    tbl[10] = '{8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[12] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[13] = '{8'h10, 1'b1, 1'b1, 3'd4, 8'h10, 1'b0};
    tbl[14] = '{8'hFF, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0};
    tbl[15] = '{8'hFF, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0};

    rr_exp1 = '{3, 2, 1, 0, 3, 2};
    rr_exp2 = '{3, 1, 3, 1, 0, 0};

    // Reset held two cycles with all requests high
    tick();
    tick();
    chk8("reset", 1'b0, 3'd0, 8'h00, 1'b1);
    rst = 1'b0;
    tick();
    chk8("post_reset", 1'b1, 3'd7, 8'h80, 1'b0);

    // Fixed-priority table
    for (int i = 0; i < 16; i++) begin
      req8 = tbl[i].req;
      rdy8 = tbl[i].rdy;
      tick();
      chk8($sformatf("fix[%0d]", i), tbl[i].v, tbl[i].idx, tbl[i].gnt, tbl[i].none);
    end
    req8 = '0; rdy8 = 1'b0;

    // Round-robin full rotation, N=4
    req4 = 4'b1111; rdy4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_all[%0d].valid", i), 32'(vld4), 32'd1);
      chk($sformatf("rr_all[%0d].idx", i),   32'(idx4), 32'(rr_exp1[i]));
      chk($sformatf("rr_all[%0d].gnt", i),   32'(gnt4), 32'(4'b0001 << rr_exp1[i]));
    end

    // Round-robin skip/wrap then single requester, from a fresh pointer
    req4 = '0; rst = 1'b1;
    tick();
    chk("rr_reset.valid", 32'(vld4), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req4 = (i < 4) ? 4'b1010 : 4'b0001;
      tick();
      chk($sformatf("rr_skip[%0d].valid", i), 32'(vld4), 32'd1);
      chk($sformatf("rr_skip[%0d].idx", i),   32'(idx4), 32'(rr_exp2[i]));
      chk($sformatf("rr_skip[%0d].gnt", i),   32'(gnt4), 32'(4'b0001 << rr_exp2[i]));
    end
    req4 = '0; rdy4 = 1'b0;

    // Move the N=8 RR pointer to 5, then reset while a grant is pending
    req8r = 8'h20; rdy8r = 1'b1;
    tick();
    chk("rst_mid.first_idx", 32'(idx8r), 32'd5);
    tick();
    chk("rst_mid.repeat_idx", 32'(idx8r), 32'd5);
    rdy8r = 1'b0;
    tick();
    chk("rst_mid.held_valid", 32'(vld8r), 32'd1);
    chk("rst_mid.held_idx",   32'(idx8r), 32'd5);
    req8r = 8'h21; rst = 1'b1;
    tick();
    chk("rst_mid.valid", 32'(vld8r),  32'd0);
    chk("rst_mid.idx",   32'(idx8r),  32'd0);
    chk("rst_mid.gnt",   32'(gnt8r),  32'd0);
    chk("rst_mid.none",  32'(none8r), 32'd1);
    rst = 1'b0;
    tick();
    chk("rst_mid.restart_idx", 32'(idx8r), 32'd5);
    chk("rst_mid.restart_gnt", 32'(gnt8r), 32'h20);
    rdy8r = 1'b1;
    tick();
    chk("rst_mid.rotate_idx", 32'(idx8r), 32'd0);
    chk("rst_mid.rotate_gnt", 32'(gnt8r), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
